ad_capture_seq: RTL and testbench

- Parametrised successor to the fixed single-channel, fixed-length A/D capture path.
- Multi-channel trigger-driven acquisition sequencer: arm, trigger edge detect, programmable post-trigger delay, decimated capture of a programmable record length.
- Auto-retrigger mode; output through an internal FIFO with valid/ready handshake and frame markers.
- Sits between the A/D sampling registers and the USB packer; whole block in the A/D clock domain.

---
 rtl/ad_capture_seq.sv | 173 +++++++++++++++++
 tb/tb_ad_capture_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_capture_seq.sv
// Trigger-driven multi-channel A/D acquisition sequencer with post-trigger delay,
// decimated fixed-length capture, optional auto re-arm and a FWFT output FIFO.
module ad_capture_seq #(
  parameter int DW    = 8,
  parameter int NCH   = 2,
  parameter int CNT_W = 16,
  parameter int DLY_W = 16,
  parameter int DEC_W = 4,
  parameter int DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NCH*DW-1:0]     i_ad_data,
  input  logic                  i_trig,
  input  logic                  i_arm,
  input  logic                  i_auto,
  input  logic                  i_stop,
  input  logic [DLY_W-1:0]      i_delay,
  input  logic [CNT_W-1:0]      i_recv_count,
  input  logic [DEC_W-1:0]      i_decim,
  output logic [NCH*DW-1:0]     o_data,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic [15:0]           o_frame_cnt
);

  localparam int SW = NCH * DW;
  localparam int FW = SW + 2;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, DELAY, CAPTURE} state_t;

  state_t           state_q;
  logic             trig_q;
  logic [DLY_W-1:0] dly_q;
  logic [CNT_W-1:0] rem_q;
  logic [DEC_W-1:0] k_q;
  logic [DEC_W-1:0] dec_q;
  logic             auto_q;
  logic             first_q;
  logic             busy_q;
  logic             ovr_q;
  logic [15:0]      frame_q;

  logic             trig_edge;
  logic             wr_req;
  logic             wr_last;

  logic [FW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [SW-1:0]    hold_q;
  logic [FW-1:0]    head;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign trig_edge = i_trig & ~trig_q;
  // A sample slot is due whenever the decimation counter has run down; an abort
  // on that same edge suppresses the write.
  assign wr_req    = (state_q == CAPTURE) && (dec_q == '0) && !i_stop;
  assign wr_last   = (rem_q == CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      dly_q   <= '0;
      rem_q   <= '0;
      k_q     <= '0;
      dec_q   <= '0;
      auto_q  <= 1'b0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      trig_q <= i_trig;
      busy_q <= (state_q != IDLE);
      if (i_stop) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_arm) state_q <= ARMED;
          end
          ARMED: begin
            if (trig_edge && (i_recv_count != '0)) begin
              dly_q   <= i_delay;
              rem_q   <= i_recv_count;
              k_q     <= i_decim;
              auto_q  <= i_auto;
              dec_q   <= '0;
              first_q <= 1'b1;
              frame_q <= frame_q + 16'd1;
              state_q <= (i_delay != '0) ? DELAY : CAPTURE;
            end
          end
          DELAY: begin
            if (dly_q == DLY_W'(1)) state_q <= CAPTURE;
            else                    dly_q   <= dly_q - DLY_W'(1);
          end
          CAPTURE: begin
            if (dec_q == '0) begin
              first_q <= 1'b0;
              dec_q   <= k_q;
              rem_q   <= rem_q - CNT_W'(1);
              if (wr_last) state_q <= auto_q ? ARMED : IDLE;
            end else begin
              dec_q <= dec_q - DEC_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Output FIFO: full is judged on the pre-edge occupancy, so a read on the
  // same edge never rescues a write.
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign do_wr = wr_req && !full;
  assign do_rd = (cnt_q != '0) && i_ready;
  assign head  = mem_q[rp_q];

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_wr) wp_d = wp_q + AW'(1);
    if (do_rd) rp_d = rp_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) mem_q[wp_q] <= {wr_last, first_q, i_ad_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      if (do_rd) hold_q <= head[SW-1:0];
      if (wr_req && full)                                ovr_q <= 1'b1;
      else if ((state_q == IDLE) && i_arm && !i_stop)    ovr_q <= 1'b0;
    end
  end

  // While empty the last consumed word is presented so the bus stays quiet.
  assign o_valid     = (cnt_q != '0);
  assign o_data      = o_valid ? head[SW-1:0] : hold_q;
  assign o_first     = o_valid & head[SW];
  assign o_last      = o_valid & head[SW+1];
  assign o_busy      = busy_q;
  assign o_overrun   = ovr_q;
  assign o_frame_cnt = frame_q;

endmodule

// File: tb/tb_ad_capture_seq.sv
// Self-checking bench for ad_capture_seq: directed scenarios plus random traffic,
// all checked every cycle against a schedule-based acquisition model.
module tb_ad_capture_seq;
  localparam int DW = 8, NCH = 2, CNT_W = 16, DLY_W = 16, DEC_W = 4, DEPTH = 16;
  localparam int W = NCH * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1, trig = 1'b0, arm = 1'b0, auto_m = 1'b0, stop = 1'b0, ready = 1'b1;
  logic [W-1:0]     ad = '0;
  logic [DLY_W-1:0] delay = '0;
  logic [CNT_W-1:0] rcount = '0;
  logic [DEC_W-1:0] decim = '0;
  logic [W-1:0]     o_data;
  logic             o_first, o_last, o_valid, o_busy, o_overrun;
  logic [15:0]      o_frame_cnt;

  ad_capture_seq #(.DW(DW), .NCH(NCH), .CNT_W(CNT_W), .DLY_W(DLY_W), .DEC_W(DEC_W), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_ad_data(ad), .i_trig(trig), .i_arm(arm), .i_auto(auto_m),
    .i_stop(stop), .i_delay(delay), .i_recv_count(rcount), .i_decim(decim),
    .o_data(o_data), .o_first(o_first), .o_last(o_last), .o_valid(o_valid), .i_ready(ready),
    .o_busy(o_busy), .o_overrun(o_overrun), .o_frame_cnt(o_frame_cnt)
  );

  typedef struct packed { logic [W-1:0] d; logic f; logic l; } word_t;

  int          n_checks = 0, n_fail = 0;
  int          t = 0;
  bit          ramp = 1'b1;
  // model: phase 0 = idle, 1 = waiting for trigger, 2 = frame scheduled/running
  int          ph = 0, s_start = 0, s_step = 1, s_n = 0;
  bit          s_auto = 1'b0, m_prev = 1'b0, m_ovr = 1'b0, m_busy = 1'b0;
  logic [15:0] m_fcnt = '0;
  logic [W-1:0] m_hold = '0;
  word_t       q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, t);
    end
  endtask

  task automatic step();
    int    ph0, n;
    bit    push, full0, edge_s;
    word_t w;
    @(posedge clk);
    t++;
    push = 1'b0;
    w = '0;
    if (rst) begin
      ph = 0; m_prev = 1'b0; m_ovr = 1'b0; m_busy = 1'b0; m_fcnt = '0; m_hold = '0;
      q.delete();
    end else begin
      ph0 = ph;
      edge_s = trig && !m_prev;
      if (stop) ph = 0;
      else if (ph == 0) begin
        if (arm) begin ph = 1; m_ovr = 1'b0; end
      end else if (ph == 1) begin
        if (edge_s && rcount != 0) begin
          m_fcnt++;
          s_start = t + 1 + int'(delay);
          s_step  = int'(decim) + 1;
          s_n     = int'(rcount);
          s_auto  = auto_m;
          ph = 2;
        end
      end else if (t >= s_start && ((t - s_start) % s_step) == 0) begin
        n = (t - s_start) / s_step;
        w = '{d: ad, f: (n == 0), l: (n == s_n - 1)};
        push = 1'b1;
        if (n == s_n - 1) ph = s_auto ? 1 : 0;
      end
      m_prev = trig;
      m_busy = (ph0 != 0);
      full0 = (q.size() >= DEPTH);
      if (push && full0) m_ovr = 1'b1;
      if (q.size() > 0 && ready) begin
        m_hold = q[0].d;
        void'(q.pop_front());
      end
      if (push && !full0) q.push_back(w);
    end
    #1;
    check_eq("valid", o_valid, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("data", o_data, q[0].d);
      check_eq("first", o_first, q[0].f);
      check_eq("last", o_last, q[0].l);
    end else begin
      check_eq("hold", o_data, m_hold);
    end
    check_eq("busy", o_busy, m_busy);
    check_eq("fcnt", o_frame_cnt, m_fcnt);
    check_eq("ovr", o_overrun, m_ovr);
    ad = ramp ? W'(32'h0100 + t + 1) : W'($urandom);
  endtask

  task automatic cfg(input int d, input int k, input int n);
    delay = DLY_W'(d); decim = DEC_W'(k); rcount = CNT_W'(n);
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic trig_pulse(output int te);
    trig = 1'b1; step(); te = t; trig = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((q.size() != 0 || ph == 2) && k < 400) begin step(); k++; end
    check_eq(tag, (k >= 400), 0);
  endtask

  initial begin
    int T, k, nw, nl;
    step(); step();
    rst = 1'b0;
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_fcnt", o_frame_cnt, 0);
    check_eq("rst_ovr", o_overrun, 0);
    check_eq("rst_data", o_data, 0);

    // basic frame
    cfg(0, 0, 4); ready = 1'b1;
    pulse_arm(); step();
    trig_pulse(T);
    step();
    check_eq("basic_w0_valid", o_valid, 1);
    check_eq("basic_w0_data", o_data, W'(32'h0100 + T + 1));
    check_eq("basic_w0_first", o_first, 1);
    step(); step(); step();
    check_eq("basic_w3_data", o_data, W'(32'h0100 + T + 4));
    check_eq("basic_w3_last", o_last, 1);
    step(); step();
    check_eq("basic_fcnt", o_frame_cnt, 1);
    check_eq("basic_busy", o_busy, 0);

    // delay and decimation
    cfg(5, 2, 3);
    pulse_arm(); step();
    trig_pulse(T);
    k = 0;
    while (!o_valid && k < 30) begin step(); k++; end
    check_eq("dly_first_vld_edge", t + 1, T + 7);
    check_eq("dly_w0_data", o_data, W'(32'h0100 + T + 6));
    drain("dly_timeout");

    // auto re-arm, with one edge landing mid-capture
    auto_m = 1'b1; cfg(0, 1, 2);
    pulse_arm(); step();
    for (int f = 0; f < 3; f++) begin
      trig_pulse(T);
      if (f == 0) begin step(); trig = 1'b1; step(); trig = 1'b0; repeat (7) step(); end
      else repeat (9) step();
    end
    check_eq("auto_fcnt", o_frame_cnt, 5);
    check_eq("auto_busy", o_busy, 1);
    auto_m = 1'b0; pulse_stop(); step();

    // backpressure and overrun
    ready = 1'b0; cfg(0, 0, 20);
    pulse_arm(); step();
    trig_pulse(T);
    repeat (16) step();
    check_eq("bp_ovr_before", o_overrun, 0);
    step();
    check_eq("bp_ovr_after", o_overrun, 1);
    repeat (5) step();
    ready = 1'b1; nw = 0; nl = 0; k = 0;
    while (o_valid && k < 40) begin nw++; nl += int'(o_last); step(); k++; end
    check_eq("bp_words", nw, DEPTH);
    check_eq("bp_lasts", nl, 0);
    pulse_arm();
    check_eq("bp_ovr_clear", o_overrun, 0);

    // abort mid-capture
    cfg(0, 0, 8); step();
    trig_pulse(T);
    step(); step();
    pulse_stop();
    step();
    check_eq("abort_busy", o_busy, 0);
    drain("abort_timeout");

    // stop coincident with a trigger edge
    pulse_arm(); step();
    trig = 1'b1; stop = 1'b1; step(); trig = 1'b0; stop = 1'b0;
    step(); step();
    check_eq("stoptrig_fcnt", o_frame_cnt, 7);
    check_eq("stoptrig_busy", o_busy, 0);

    // zero-length record trigger is ignored
    pulse_arm(); step();
    cfg(0, 0, 0);
    trig_pulse(T); step(); step();
    check_eq("n0_fcnt", o_frame_cnt, 7);
    check_eq("n0_busy", o_busy, 1);
    pulse_stop(); step();

    // reset during capture with words buffered
    ready = 1'b0; cfg(0, 0, 10);
    pulse_arm(); step();
    trig_pulse(T);
    repeat (5) step();
    check_eq("rstmid_pre_valid", o_valid, 1);
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("rstmid_valid", o_valid, 0);
    check_eq("rstmid_busy", o_busy, 0);
    check_eq("rstmid_fcnt", o_frame_cnt, 0);
    check_eq("rstmid_ovr", o_overrun, 0);

    // randomized traffic
    ramp = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      ready  = ($urandom_range(0, 99) < ((c % 800) < 200 ? 10 : 75));
      if ($urandom_range(0, 3) == 0) trig = ~trig;
      arm    = ($urandom_range(0, 15) == 0);
      stop   = ($urandom_range(0, 199) == 0);
      rst    = ($urandom_range(0, 1499) == 0);
      if ((c % 500) == 0) auto_m = $urandom_range(0, 1);
      delay  = ($urandom_range(0, 3) == 0) ? DLY_W'($urandom_range(1, 8)) : '0;
      decim  = ($urandom_range(0, 19) == 0) ? DEC_W'(15) : DEC_W'($urandom_range(0, 3));
      rcount = CNT_W'($urandom_range(0, 6));
      step();
    end
    arm = 1'b0; rst = 1'b0; ready = 1'b1; trig = 1'b0;
    pulse_stop();
    drain("rand_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
